mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port 16-bit word memory between the stack CPU (port 0) and a program loader/debug master (port 1). Grants one memory beat per cycle, registers the memory command, and returns read data tagged to the issuing port. Fairness comes from round-robin on contention plus a bounded burst tenure. It sits between the masters and the memory macro in the top level.

## Interface
Parameters:
- `ADDR_W`, default 16: word-address width.
- `DATA_W`, default 16: data width.
- `BURST_MAX`, default 4: maximum consecutive beats one owner may take while the other port requests. Legal range is at least 1.

Ports (p = 0, 1):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_p` in 1: port p requests a beat this cycle.
- `we_p` in 1: beat is a write (1) or a read (0).
- `addr_p` in ADDR_W: word address.
- `wdata_p` in DATA_W: write data.
- `gnt_p` out 1: combinational; the beat is accepted at this rising edge when `req_p & gnt_p`.
- `rvalid_p` out 1: registered; read data for port p is valid this cycle.
- `rdata_p` out DATA_W: registered read data.
- `mem_addr` out ADDR_W: registered memory address.
- `mem_wdata` out DATA_W: registered memory write data.
- `mem_we` out 1: registered memory write enable.
- `mem_rd` out 1: registered memory read enable.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after `mem_rd`.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- Registers:
  - `beats` counts beats accepted in the current tenure; width `$clog2(BURST_MAX+1)`, saturating at BURST_MAX.
  - `last` holds the index of the most recent owner.
- At most one of `gnt_0`, `gnt_1` is high in any cycle. A grant is never asserted to a port whose `req` is low.
- IDLE:
  - Only one port requests: grant that port.
  - Both request: grant `!last`.
  - Next state is OWNp with `beats` = 1.
- OWNp, owner requesting:
  - Owner keeps the grant if the other port is idle, or if `beats < BURST_MAX`; `beats` increments.
  - Otherwise the other port is granted, next state is OWN(other), `beats` = 1.
- OWNp, owner not requesting:
  - Other port requests: grant it, next state is OWN(other), `beats` = 1.
  - Otherwise: no grant, next state is IDLE, `beats` = 0.
- While the other port is idle, a lone owner streams indefinitely; `beats` saturates and does not wrap.
- On every accept, the granted port's `addr`, `wdata` and `we` are registered onto `mem_*`.
  - `mem_rd` = !we; `mem_we` = we.
  - A 1-bit port tag is pushed into a 2-stage read-return pipe.
- With no accept, `mem_we` and `mem_rd` are 0 the next cycle; `mem_addr` and `mem_wdata` hold their values.
- Read return: the cycle after `mem_rd`, `rdata_tag` captures `mem_rdata`. The next cycle, `rvalid_tag` = 1 for one cycle.
- Writes produce no `rvalid`.
- Back-to-back reads from alternating ports return in issue order, one per cycle, each on its own port.

## Timing
- Accept edge N: `mem_*` valid during cycle N+1. Read data is on `rdata_p` with `rvalid_p` during cycle N+3. Throughput is 1 beat/cycle.
- Arbitration is Mealy. `gnt` depends on the current `req_*`, state, `beats` and `last`, with zero-cycle latency from `req` to `gnt`.
- Masters must hold `req`, `we`, `addr` and `wdata` stable until an edge at which `gnt` is high.
- Reset values:
  - state IDLE; `beats` 0.
  - `last` = 1, so port 0 wins the first tie.
  - `mem_addr`, `mem_wdata` = 0; `mem_we`, `mem_rd` = 0.
  - `rvalid_0`, `rvalid_1` = 0; `rdata_0`, `rdata_1` = 0.
  - Read-return pipe cleared.
- Reset mid-operation: in-flight reads are dropped and no `rvalid` is issued. A write registered in the reset cycle is discarded, because `mem_we` is forced to 0.
- Simultaneous requests at the burst boundary: the switch to the other port happens on the beat where `beats == BURST_MAX`, with no idle cycle.
- BURST_MAX = 1: strict alternation under continuous contention.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, OWN0, OWN1)
  - port index constants `PORT_CPU` = 0, `PORT_LOAD` = 1
  - reset value of `last`
- One sub-module, `mem_arb_pick`: combinational grant/next-state logic over `req`, state, `beats` and `last`. It is unit-testable in isolation.
- The top level holds the registers, the `mem_*` output stage and the read-return pipe.

## Test plan
- Reset, then `req_0` alone reads `addr` 0x0010 with memory returning 0xBEEF:
  - `gnt_0` immediate.
  - `mem_rd` = 1 with `mem_addr` 0x0010 next cycle.
  - `rvalid_0` = 1 with `rdata_0` 0xBEEF at N+3.
  - `rvalid_1` stays 0.
- Both ports request continuously, BURST_MAX = 4: grant sequence 0,0,0,0,1,1,1,1,0… with no bubble cycles.
- Port 1 streams 10 writes alone, then port 0 requests at beat 10: port 0 is granted on the next beat, and `beats` has saturated at 4, not wrapped.
- Alternating reads, port 0 at 0x1 and port 1 at 0x2, memory returning 0xA1 then 0xB2: `rdata_0` = 0xA1, then `rdata_1` = 0xB2 on consecutive cycles with correct `rvalid` tags.
- Assert `rst` one cycle after a read is accepted:
  - no `rvalid` ever appears for that read
  - all outputs at reset values
  - the first post-reset tie goes to port 0
- BURST_MAX = 1 under full contention: strict 0,1,0,1 alternation. One-hot grant and grant-only-when-req assertions hold for the whole run.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Covers the arbitration state encoding, port indices and reset ownership.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // Pretending the loader owned last makes the CPU win the first tie.
    localparam logic LAST_RST = PORT_LOAD;

    function automatic arb_state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant and next-state selection for the two-port arbiter.
// Round-robin on ties, with tenure limited to BURST_MAX beats under contention.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int BEATS_W   = $clog2(BURST_MAX + 1)
) (
    input  logic [1:0]         req,
    input  arb_state_t         state,
    input  logic [BEATS_W-1:0] beats,
    input  logic               last,
    output logic [1:0]         gnt,
    output arb_state_t         state_nxt,
    output logic [BEATS_W-1:0] beats_nxt,
    output logic               last_nxt
);

    localparam logic [BEATS_W-1:0] BMAX = BEATS_W'(BURST_MAX);
    localparam logic [BEATS_W-1:0] ONE  = BEATS_W'(1);

    logic owner;
    logic pick;
    logic pick_valid;
    logic keep;

    always_comb begin
        gnt        = '0;
        state_nxt  = IDLE;
        beats_nxt  = '0;
        last_nxt   = last;
        owner      = (state == OWN1);
        pick       = 1'b0;
        pick_valid = 1'b0;
        keep       = 1'b0;

        case (state)
            IDLE: begin
                if (req[0] && req[1]) begin
                    pick       = !last;
                    pick_valid = 1'b1;
                end else if (req[0]) begin
                    pick       = PORT_CPU;
                    pick_valid = 1'b1;
                end else if (req[1]) begin
                    pick       = PORT_LOAD;
                    pick_valid = 1'b1;
                end
            end
            default: begin
                if (req[owner] && (!req[!owner] || beats < BMAX)) begin
                    pick       = owner;
                    pick_valid = 1'b1;
                    keep       = 1'b1;
                    beats_nxt  = (beats == BMAX) ? BMAX : beats + ONE;
                end else if (req[!owner]) begin
                    pick       = !owner;
                    pick_valid = 1'b1;
                end
            end
        endcase

        if (pick_valid) begin
            gnt[pick] = 1'b1;
            state_nxt = own_state(pick);
            last_nxt  = pick;
            if (!keep) begin
                beats_nxt = ONE;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared single-port word memory.
// Registers one memory command per cycle and returns read data to the issuing port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEATS_W = $clog2(BURST_MAX + 1);

    arb_state_t         state, state_nxt;
    logic [BEATS_W-1:0] beats, beats_nxt;
    logic               last, last_nxt;
    logic [1:0]         gnt;
    logic               accept;
    logic               sel;
    logic               we_sel;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    logic [1:0]         pipe_v;
    logic [1:0]         pipe_tag;

    mem_arb_pick #(
        .BURST_MAX (BURST_MAX),
        .BEATS_W   (BEATS_W)
    ) u_pick (
        .req       ({req_1, req_0}),
        .state     (state),
        .beats     (beats),
        .last      (last),
        .gnt       (gnt),
        .state_nxt (state_nxt),
        .beats_nxt (beats_nxt),
        .last_nxt  (last_nxt)
    );

    assign gnt_0     = gnt[0];
    assign gnt_1     = gnt[1];
    assign accept    = |(gnt & {req_1, req_0});
    assign sel       = gnt[1];
    assign we_sel    = sel ? we_1 : we_0;
    assign addr_sel  = sel ? addr_1 : addr_0;
    assign wdata_sel = sel ? wdata_1 : wdata_0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beats <= '0;
            last  <= LAST_RST;
        end else begin
            state <= state_nxt;
            beats <= beats_nxt;
            last  <= last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
        end else if (accept) begin
            mem_addr  <= addr_sel;
            mem_wdata <= wdata_sel;
            mem_we    <= we_sel;
            mem_rd    <= !we_sel;
        end else begin
            mem_we    <= 1'b0;
            mem_rd    <= 1'b0;
        end
    end

    // Stage 0 lines up with mem_rd, stage 1 with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v   <= '0;
            pipe_tag <= '0;
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            pipe_v[0]   <= accept && !we_sel;
            pipe_tag[0] <= sel;
            pipe_v[1]   <= pipe_v[0];
            pipe_tag[1] <= pipe_tag[0];
            rvalid_0    <= pipe_v[1] && (pipe_tag[1] == PORT_CPU);
            rvalid_1    <= pipe_v[1] && (pipe_tag[1] == PORT_LOAD);
            if (pipe_v[1] && (pipe_tag[1] == PORT_CPU)) begin
                rdata_0 <= mem_rdata;
            end
            if (pipe_v[1] && (pipe_tag[1] == PORT_LOAD)) begin
                rdata_1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: BURST_MAX=4 main instance plus a BURST_MAX=1 instance.
// Reads are queued with expected port, data and arrival cycle; a monitor retires them.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req_0, we_0, req_1, we_1;
    logic [15:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [15:0] rdata_0, rdata_1;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_rd;

    logic        b_req_0, b_req_1;
    logic        b_gnt_0, b_gnt_1, b_rvalid_0, b_rvalid_1;
    logic [15:0] b_rdata_0, b_rdata_1, b_mem_addr, b_mem_wdata;
    logic        b_mem_we, b_mem_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        port;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST_MAX(1)) dut_b1 (
        .clk(clk), .rst(rst),
        .req_0(b_req_0), .we_0(1'b1), .addr_0(16'h0100), .wdata_0(16'h00AA),
        .req_1(b_req_1), .we_1(1'b1), .addr_1(16'h0200), .wdata_1(16'h00BB),
        .gnt_0(b_gnt_0), .gnt_1(b_gnt_1),
        .rvalid_0(b_rvalid_0), .rdata_0(b_rdata_0),
        .rvalid_1(b_rvalid_1), .rdata_1(b_rdata_1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_we(b_mem_we), .mem_rd(b_mem_rd), .mem_rdata(16'h0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0001: return 16'h00A1;
            16'h0002: return 16'h00B2;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory macro model: data for the address presented this cycle appears next cycle.
    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid_0 || rvalid_1) begin
            chk("rvalid_onehot", {31'd0, rvalid_0 & rvalid_1}, 0);
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", {31'd0, rvalid_1}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rvalid_port", {31'd0, rvalid_1}, {31'd0, e.port});
                chk("rdata", {16'd0, (rvalid_1 ? rdata_1 : rdata_0)}, {16'd0, e.data});
                chk("rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        #1;
        chk("onehot_a", {31'd0, gnt_0 & gnt_1}, 0);
        chk("gnt_req_a", {31'd0, (gnt_0 & !req_0) | (gnt_1 & !req_1)}, 0);
        chk("onehot_b", {31'd0, b_gnt_0 & b_gnt_1}, 0);
        chk("gnt_req_b", {31'd0, (b_gnt_0 & !b_req_0) | (b_gnt_1 & !b_req_1)}, 0);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (req_0 && !we_0 && gnt_0) exp_q.push_back('{1'b0, mem_fn(addr_0), cyc + 3});
            if (req_1 && !we_1 && gnt_1) exp_q.push_back('{1'b1, mem_fn(addr_1), cyc + 3});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_0 = 1'b0;
        req_1 = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_addr"},  {16'd0, mem_addr}, 0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 0);
        chk({tag, "_mem_we"},    {31'd0, mem_we}, 0);
        chk({tag, "_mem_rd"},    {31'd0, mem_rd}, 0);
        chk({tag, "_rvalid"},    {30'd0, rvalid_1, rvalid_0}, 0);
        chk({tag, "_rdata_0"},   {16'd0, rdata_0}, 0);
        chk({tag, "_rdata_1"},   {16'd0, rdata_1}, 0);
        chk({tag, "_beats"},     32'(dut.beats), 0);
    endtask

    int seq4[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        rst = 1'b1;
        req_0 = 0; we_0 = 0; addr_0 = 0; wdata_0 = 0;
        req_1 = 0; we_1 = 0; addr_1 = 0; wdata_1 = 0;
        b_req_0 = 0; b_req_1 = 0;
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");
        chk("reset_gnt", {30'd0, gnt_1, gnt_0}, 0);
        @(negedge clk);

        // Single read from port 0.
        req_0 = 1; we_0 = 0; addr_0 = 16'h0010;
        #1;
        chk("single_gnt_0", {31'd0, gnt_0}, 1);
        chk("single_gnt_1", {31'd0, gnt_1}, 0);
        step();
        req_0 = 0;
        chk("single_mem_rd", {31'd0, mem_rd}, 1);
        chk("single_mem_we", {31'd0, mem_we}, 0);
        chk("single_mem_addr", {16'd0, mem_addr}, 32'h0010);
        idle(5);

        // Make port 1 the last owner so the next tie goes to port 0.
        req_1 = 1; we_1 = 0; addr_1 = 16'h0004;
        #1;
        chk("prep_gnt_1", {31'd0, gnt_1}, 1);
        step();
        idle(2);

        // Full contention, BURST_MAX=4.
        req_0 = 1; we_0 = 0; addr_0 = 16'h0003;
        req_1 = 1; we_1 = 0; addr_1 = 16'h0004;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("contend_gnt_0", {31'd0, gnt_0}, {31'd0, seq4[i] == 0});
            chk("contend_gnt_1", {31'd0, gnt_1}, {31'd0, seq4[i] == 1});
            step();
        end
        idle(5);

        // Port 1 streams ten writes alone, then port 0 joins.
        for (int i = 0; i < 10; i++) begin
            req_1 = 1; we_1 = 1; addr_1 = 16'h0020 + 16'(i); wdata_1 = 16'h0100 + 16'(i);
            #1;
            chk("stream_gnt_1", {31'd0, gnt_1}, 1);
            step();
            chk("stream_mem_we", {31'd0, mem_we}, 1);
            chk("stream_mem_rd", {31'd0, mem_rd}, 0);
            chk("stream_mem_addr", {16'd0, mem_addr}, 32'h0020 + i);
            chk("stream_mem_wdata", {16'd0, mem_wdata}, 32'h0100 + i);
        end
        chk("beats_sat", 32'(dut.beats), 4);
        req_1 = 1; we_1 = 1; addr_1 = 16'h002A; wdata_1 = 16'h010A;
        req_0 = 1; we_0 = 0; addr_0 = 16'h0030;
        #1;
        chk("switch_gnt_0", {31'd0, gnt_0}, 1);
        chk("switch_gnt_1", {31'd0, gnt_1}, 0);
        step();
        req_0 = 0;
        #1;
        chk("resume_gnt_1", {31'd0, gnt_1}, 1);
        step();
        idle(5);

        // Alternating reads returned in order on their own ports.
        req_0 = 1; we_0 = 0; addr_0 = 16'h0001;
        #1;
        chk("alt_gnt_0", {31'd0, gnt_0}, 1);
        step();
        req_0 = 0;
        req_1 = 1; we_1 = 0; addr_1 = 16'h0002;
        #1;
        chk("alt_gnt_1", {31'd0, gnt_1}, 1);
        step();
        idle(5);

        // Reset one cycle after a read is accepted, with a write offered during reset.
        req_0 = 1; we_0 = 0; addr_0 = 16'h0040;
        #1;
        chk("rst_rd_gnt_0", {31'd0, gnt_0}, 1);
        step();
        rst = 1;
        req_0 = 0;
        req_1 = 1; we_1 = 1; addr_1 = 16'h0055; wdata_1 = 16'h1234;
        step();
        rst = 0;
        req_1 = 0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        idle(4);
        req_0 = 1; we_0 = 0; addr_0 = 16'h0005;
        req_1 = 1; we_1 = 0; addr_1 = 16'h0006;
        #1;
        chk("post_rst_tie_0", {31'd0, gnt_0}, 1);
        chk("post_rst_tie_1", {31'd0, gnt_1}, 0);
        step();
        idle(5);

        // BURST_MAX=1 instance under full contention.
        b_req_0 = 1; b_req_1 = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("b1_gnt_0", {31'd0, b_gnt_0}, {31'd0, (i % 2) == 0});
            chk("b1_gnt_1", {31'd0, b_gnt_1}, {31'd0, (i % 2) == 1});
            step();
        end
        b_req_0 = 0; b_req_1 = 0;
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
